// File: rtl/activation_pipe.sv
// Two-stage valid/ready activation pipeline: S1 registers the beat, S2 holds the
// per-lane activation result (pass, ReLU, clamped ReLU, leaky ReLU) plus a clip counter.
module activation_pipe #(
   parameter int LANES      = 4,
   parameter int DW         = 8,
   parameter int LEAK_SHIFT = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [LANES*DW-1:0]   in_data,
   input  logic [1:0]            in_mode,
   input  logic [DW-1:0]         cap,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [LANES*DW-1:0]   out_data,
   output logic [15:0]           clip_count
);

   localparam logic [1:0] M_PASS  = 2'b00;
   localparam logic [1:0] M_RELU  = 2'b01;
   localparam logic [1:0] M_CLAMP = 2'b10;
   localparam logic [1:0] M_LEAKY = 2'b11;

   logic                  vld_p1, vld_p2, adv_p2;
   logic [LANES*DW-1:0]   data_p1, res_p1, data_p2;
   logic [1:0]            mode_p1;
   logic signed [DW-1:0]  cap_p1, capeff_p1;
   logic [4:0]            nclip_p1;
   logic [15:0]           clip_p2;

   function automatic logic signed [DW-1:0] act_lane(input logic signed [DW-1:0] x,
                                                     input logic [1:0]           m,
                                                     input logic signed [DW-1:0] ce);
      logic signed [DW-1:0] y;
      y = x;
      case (m)
         M_PASS:  y = x;
         M_RELU:  y = (x < 0) ? {DW{1'b0}} : x;
         M_CLAMP: begin
            if (x < 0)       y = {DW{1'b0}};
            else if (x > ce) y = ce;
            else             y = x;
         end
         M_LEAKY: y = (x < 0) ? (x >>> LEAK_SHIFT) : x;
         default: y = x;
      endcase
      return y;
   endfunction

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [4:0] n);
      logic [16:0] s;
      s = {1'b0, a} + {12'd0, n};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   // A full S2 can only drain when downstream accepts; S1 follows the same condition.
   assign adv_p2   = !vld_p2 || out_ready;
   assign in_ready = !vld_p1 || adv_p2;

   // ---- stage 1 -> stage 2 boundary: activation and clip tally ----
   assign capeff_p1 = (cap_p1 < 0) ? {DW{1'b0}} : cap_p1;

   always_comb begin
      res_p1   = '0;
      nclip_p1 = '0;
      for (int i = 0; i < LANES; i++) begin
         res_p1[i*DW +: DW] = act_lane(data_p1[i*DW +: DW], mode_p1, capeff_p1);
         if (mode_p1 == M_CLAMP && $signed(data_p1[i*DW +: DW]) > capeff_p1)
            nclip_p1 = nclip_p1 + 5'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         vld_p2  <= 1'b0;
         clip_p2 <= '0;
      end else begin
         if (in_ready)
            vld_p1 <= in_valid;
         if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1)
               clip_p2 <= sat_add16(clip_p2, nclip_p1);
         end
      end
   end

   // ---- input -> stage 1 boundary ----
   always_ff @(posedge clk) begin
      if (in_ready && in_valid && !rst) begin
         data_p1 <= in_data;
         mode_p1 <= in_mode;
         cap_p1  <= cap;
      end
   end

   // ---- stage 2 boundary: output register, cleared so reset shows zero data ----
   always_ff @(posedge clk) begin
      if (rst)
         data_p2 <= '0;
      else if (adv_p2 && vld_p1)
         data_p2 <= res_p1;
   end

   assign out_valid  = vld_p2;
   assign out_data   = data_p2;
   assign clip_count = clip_p2;

endmodule

// File: tb/tb_activation_pipe.sv
// Bench for activation_pipe: directed vector table and corner sequences on a default
// instance, randomized scoreboard run on an 8-lane 12-bit instance.
module tb_activation_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [31:0] a_in_data, a_out_data;
   logic [1:0]  a_in_mode;
   logic [7:0]  a_cap;
   logic [15:0] a_clip;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [95:0] b_in_data, b_out_data;
   logic [1:0]  b_in_mode;
   logic [11:0] b_cap;
   logic [15:0] b_clip;

   activation_pipe u_a (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_data(a_in_data), .in_mode(a_in_mode), .cap(a_cap),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .clip_count(a_clip));

   activation_pipe #(.LANES(8), .DW(12), .LEAK_SHIFT(5)) u_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .in_mode(b_in_mode), .cap(b_cap),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .clip_count(b_clip));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] pk(input int l0, input int l1, input int l2, input int l3);
      logic [31:0] r;
      r[7:0]   = l0[7:0];
      r[15:8]  = l1[7:0];
      r[23:16] = l2[7:0];
      r[31:24] = l3[7:0];
      return r;
   endfunction

   // Reference: activation rules in plain integer arithmetic (floor division for leaky).
   function automatic int ref_lane(input int x, input int m, input int c, input int sh);
      int ce, d, q;
      ce = (c < 0) ? 0 : c;
      case (m)
         0: return x;
         1: return (x < 0) ? 0 : x;
         2: return (x < 0) ? 0 : ((x > ce) ? ce : x);
         default: begin
            if (x >= 0) return x;
            d = 1 << sh;
            q = x / d;
            if (q * d != x) q = q - 1;
            return q;
         end
      endcase
   endfunction

   typedef struct {
      logic [1:0]  mode;
      int          cap;
      logic [31:0] din;
      logic [31:0] dout;
      int          clip;
   } vec_t;

   vec_t        vt[7];
   logic [31:0] bp[5];
   logic [95:0] q[$];
   int          acc, mclip, got, nx, r, cl;
   logic [95:0] expv;

   initial begin
      vt[0] = '{2'd1,    0, pk(10, -5, 127, -128), pk(10, 0, 127, 0),   0};
      vt[1] = '{2'd2,   50, pk(60, 50, -1, 127),   pk(50, 50, 0, 50),   2};
      vt[2] = '{2'd2,   -3, pk(4, 0, -4, 9),       pk(0, 0, 0, 0),      4};
      vt[3] = '{2'd3,    0, pk(-5, -128, -8, 7),   pk(-1, -16, -1, 7),  4};
      vt[4] = '{2'd0,  -77, pk(-1, 0, 127, -128),  pk(-1, 0, 127, -128), 4};
      vt[5] = '{2'd2,  127, pk(127, -128, 126, 0), pk(127, 0, 126, 0),  4};
      vt[6] = '{2'd2, -128, pk(1, 2, 3, -1),       pk(0, 0, 0, 0),      7};

      rst = 1'b1;
      a_in_valid = 0; a_in_data = '0; a_in_mode = '0; a_cap = '0; a_out_ready = 1;
      b_in_valid = 0; b_in_data = '0; b_in_mode = '0; b_cap = '0; b_out_ready = 1;
      tick; tick;
      chk("rst_out_valid", 128'(a_out_valid), 128'(0));
      chk("rst_out_data",  128'(a_out_data),  128'(0));
      chk("rst_clip",      128'(a_clip),      128'(0));
      chk("rst_in_ready",  128'(a_in_ready),  128'(1));
      rst = 1'b0;
      tick;
      chk("post_rst_in_ready", 128'(a_in_ready), 128'(1));

      // Directed vectors: one beat each, exact two-cycle latency.
      for (int i = 0; i < 7; i++) begin
         a_in_valid = 1; a_in_mode = vt[i].mode; a_cap = 8'(vt[i].cap); a_in_data = vt[i].din;
         tick;
         a_in_valid = 0;
         chk($sformatf("vec%0d_early", i), 128'(a_out_valid), 128'(0));
         tick;
         chk($sformatf("vec%0d_valid", i), 128'(a_out_valid), 128'(1));
         chk($sformatf("vec%0d_data", i),  128'(a_out_data),  128'(vt[i].dout));
         chk($sformatf("vec%0d_clip", i),  128'(a_clip),      128'(vt[i].clip));
      end
      tick;

      // Back-pressure: only two beats fit while downstream stalls.
      for (int k = 0; k < 5; k++) bp[k] = pk(k + 1, 17 * k, -k - 3, 100 - k);
      a_out_ready = 0; a_in_mode = 2'd0; acc = 0;
      for (int c = 0; c < 6; c++) begin
         a_in_valid = 1; a_in_data = bp[(acc < 5) ? acc : 4];
         #1;
         if (a_in_ready) acc++;
         tick;
      end
      chk("bp_accepted",  128'(acc),         128'(2));
      chk("bp_in_ready",  128'(a_in_ready),  128'(0));
      chk("bp_head",      128'(a_out_data),  128'(bp[0]));
      tick;
      chk("bp_stable",    128'({a_out_valid, a_out_data}), 128'({1'b1, bp[0]}));
      a_out_ready = 1;
      for (int k = 0; k < 5; k++) begin
         a_in_valid = (acc < 5); a_in_data = bp[(acc < 5) ? acc : 0];
         #1;
         if (a_in_valid && a_in_ready) acc++;
         chk($sformatf("bp_order%0d", k), 128'({a_out_valid, a_out_data}), 128'({1'b1, bp[k]}));
         tick;
      end
      a_in_valid = 0;
      tick;
      chk("bp_drained", 128'(a_out_valid), 128'(0));

      // Mid-stream reset with two buffered clamping beats and a concurrent handshake.
      a_out_ready = 0; a_in_mode = 2'd2; a_cap = 8'd0; a_in_valid = 1; a_in_data = pk(5, 5, 5, 5);
      tick; tick;
      a_out_ready = 1; a_in_data = pk(9, 9, 9, 9); rst = 1;
      tick;
      rst = 0; a_in_valid = 0;
      chk("mrst_out_valid", 128'(a_out_valid), 128'(0));
      chk("mrst_clip",      128'(a_clip),      128'(0));
      chk("mrst_in_ready",  128'(a_in_ready),  128'(1));
      got = 0;
      for (int c = 0; c < 4; c++) begin
         if (a_out_valid) got++;
         tick;
      end
      chk("mrst_no_ghost", 128'(got), 128'(0));
      a_in_valid = 1; a_in_mode = 2'd1; a_in_data = pk(-1, 2, -3, 4);
      tick;
      a_in_valid = 0;
      tick;
      chk("mrst_after", 128'({a_out_valid, a_out_data}), 128'({1'b1, pk(0, 2, 0, 4)}));
      chk("mrst_after_clip", 128'(a_clip), 128'(0));

      // Randomized run on the wide instance against the reference model.
      mclip = 0;
      for (int n = 0; n < 3000; n++) begin
         b_in_valid  = ($urandom_range(0, 3) != 0);
         b_out_ready = ($urandom_range(0, 3) != 0);
         b_in_mode   = 2'($urandom_range(0, 3));
         b_cap       = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 400)) : 12'($urandom);
         b_in_data   = {$urandom(), $urandom(), $urandom()};
         #1;
         if (b_in_valid && b_in_ready) begin
            cl = int'($signed(b_cap));
            for (int i = 0; i < 8; i++) begin
               nx = int'($signed(b_in_data[i*12 +: 12]));
               r  = ref_lane(nx, int'(b_in_mode), cl, 5);
               expv[i*12 +: 12] = r[11:0];
               if (b_in_mode == 2'd2 && nx > ((cl < 0) ? 0 : cl)) mclip++;
            end
            q.push_back(expv);
         end
         if (b_out_valid && b_out_ready) begin
            if (q.size() == 0) chk("rnd_extra_beat", 128'(b_out_data), 128'(0) ^ 128'(1) ^ 128'(b_out_data));
            else chk("rnd_beat", 128'(b_out_data), 128'(q.pop_front()));
         end
         tick;
      end
      b_in_valid = 0; b_out_ready = 1;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (b_out_valid) begin
            if (q.size() == 0) chk("rnd_extra_beat", 128'(b_out_data), 128'(0) ^ 128'(1) ^ 128'(b_out_data));
            else chk("rnd_drain_beat", 128'(b_out_data), 128'(q.pop_front()));
         end
         tick;
      end
      chk("rnd_queue_empty", 128'(q.size()), 128'(0));
      chk("rnd_clip_total",  128'(b_clip),   128'(mclip));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
